// File: rtl/isp_frame_ctrl_if.sv
// Source handshake and pipeline drive bundle for isp_frame_ctrl.
// slave = frame controller side, master = source/pipeline side.
interface isp_frame_ctrl_if #(
    parameter int CW = 9,
    parameter int RW = 8
);
    logic          iSrcValid;
    logic [7:0]    iSrcData;
    logic          oSrcReady;
    logic          oValid;
    logic [7:0]    oData;
    logic [CW-1:0] oCol;
    logic [RW-1:0] oRow;
    logic [1:0]    oColour;

    modport slave (
        input  iSrcValid, iSrcData,
        output oSrcReady, oValid, oData, oCol, oRow, oColour
    );

    modport master (
        output iSrcValid, iSrcData,
        input  oSrcReady, oValid, oData, oCol, oRow, oColour
    );
endinterface

// File: rtl/isp_frame_ctrl.sv
// Frame sequencer feeding RAW Bayer pixels into the ISP pipeline, then
// draining it until last-pixel-out (or timeout) and pulsing a clear.
module isp_frame_ctrl #(
    parameter int width    = 320,
    parameter int height   = 240,
    parameter int maxDrain = 4096
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iStart,
    isp_frame_ctrl_if.slave bus,
    input  logic            iPipeDone,
    output logic            oPipeClear,
    output logic            oBusy,
    output logic            oFrameDone,
    output logic            oTimeout
);
    localparam int CW = (width    > 1) ? $clog2(width)    : 1;
    localparam int RW = (height   > 1) ? $clog2(height)   : 1;
    localparam int DW = (maxDrain > 1) ? $clog2(maxDrain) : 1;
    localparam logic [CW-1:0] COL_LAST   = CW'(width - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(height - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(maxDrain - 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, CLEAR} state_t;

    state_t        r_state;
    logic [CW-1:0] r_colCnt, r_oCol;
    logic [RW-1:0] r_rowCnt, r_oRow;
    logic [DW-1:0] r_drain;
    logic          r_drainRun;
    logic          r_srcReady, r_valid, r_pipeClear, r_busy, r_frameDone, r_timeout;
    logic [7:0]    r_data;
    logic [1:0]    r_colour;

    logic          w_xfer, w_timeUp;
    logic [1:0]    w_colour;

    assign w_xfer   = bus.iSrcValid & r_srcReady;
    // Bayer GB/RG tile: matching row/col parity is green, else B on even rows, R on odd.
    assign w_colour = (r_rowCnt[0] == r_colCnt[0]) ? 2'd0 : (r_rowCnt[0] ? 2'd2 : 2'd1);
    assign w_timeUp = r_drainRun && (r_drain == DRAIN_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_colCnt    <= '0;
            r_rowCnt    <= '0;
            r_drain     <= '0;
            r_drainRun  <= 1'b0;
            r_srcReady  <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_oCol      <= '0;
            r_oRow      <= '0;
            r_colour    <= '0;
            r_pipeClear <= 1'b0;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_oCol      <= '0;
            r_oRow      <= '0;
            r_colour    <= '0;
            r_pipeClear <= 1'b0;
            r_frameDone <= 1'b0;
            case (r_state)
                IDLE: if (iStart) begin
                    r_state    <= FEED;
                    r_srcReady <= 1'b1;
                    r_busy     <= 1'b1;
                    r_colCnt   <= '0;
                    r_rowCnt   <= '0;
                    r_drain    <= '0;
                    r_drainRun <= 1'b0;
                    r_timeout  <= 1'b0;
                end
                FEED: if (w_xfer) begin
                    r_valid  <= 1'b1;
                    r_data   <= bus.iSrcData;
                    r_oCol   <= r_colCnt;
                    r_oRow   <= r_rowCnt;
                    r_colour <= w_colour;
                    if (r_colCnt == COL_LAST) begin
                        r_colCnt <= '0;
                        if (r_rowCnt == ROW_LAST) begin
                            r_state    <= DRAIN;
                            r_srcReady <= 1'b0;
                        end else begin
                            r_rowCnt <= r_rowCnt + 1'b1;
                        end
                    end else begin
                        r_colCnt <= r_colCnt + 1'b1;
                    end
                end
                // The first DRAIN cycle still shows the last pixel; drain counting
                // starts with the first flush (valid, zero data) cycle.
                DRAIN: begin
                    if (iPipeDone || w_timeUp) begin
                        r_state     <= CLEAR;
                        r_pipeClear <= 1'b1;
                        r_frameDone <= 1'b1;
                        r_drainRun  <= 1'b0;
                        if (!iPipeDone) r_timeout <= 1'b1;
                    end else begin
                        r_valid    <= 1'b1;
                        r_drainRun <= 1'b1;
                    end
                    if (r_drainRun && r_drain != DRAIN_LAST) r_drain <= r_drain + 1'b1;
                end
                CLEAR: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oSrcReady = r_srcReady;
    assign bus.oValid    = r_valid;
    assign bus.oData     = r_data;
    assign bus.oCol      = r_oCol;
    assign bus.oRow      = r_oRow;
    assign bus.oColour   = r_colour;
    assign oPipeClear    = r_pipeClear;
    assign oBusy         = r_busy;
    assign oFrameDone    = r_frameDone;
    assign oTimeout      = r_timeout;
endmodule

// File: tb/tb_isp_frame_ctrl.sv
// Bench for isp_frame_ctrl at width=4, height=2, maxDrain=8: vector tables,
// hand sequences for drain/timeout/reset, and randomized frames vs a model.
module tb_isp_frame_ctrl;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int MD = 8;

    logic clk = 1'b0, reset = 1'b0, iStart = 1'b0, iPipeDone = 1'b0;
    logic oPipeClear, oBusy, oFrameDone, oTimeout;
    int   nchk = 0, nerr = 0;

    isp_frame_ctrl_if #(.CW(2), .RW(1)) bus();

    isp_frame_ctrl #(.width(W), .height(H), .maxDrain(MD)) dut (
        .clk(clk), .reset(reset), .iStart(iStart), .bus(bus),
        .iPipeDone(iPipeDone), .oPipeClear(oPipeClear), .oBusy(oBusy),
        .oFrameDone(oFrameDone), .oTimeout(oTimeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         sv;
        logic [7:0] d;
        bit         ev;
        logic [7:0] ed;
        int         ec;
        int         er;
        int         eclr;
    } vec_t;
    vec_t vecs[19];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Spec rule: even row G,B; odd row R,G (G=0, B=1, R=2).
    function automatic int bayer(input int r, input int c);
        if (r % 2 == 0) return (c % 2 == 0) ? 0 : 1;
        return (c % 2 == 0) ? 2 : 0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_srcReady"}, int'(bus.oSrcReady), 0);
        chk({tag, "_valid"},    int'(bus.oValid), 0);
        chk({tag, "_data"},     int'(bus.oData), 0);
        chk({tag, "_col"},      int'(bus.oCol), 0);
        chk({tag, "_row"},      int'(bus.oRow), 0);
        chk({tag, "_colour"},   int'(bus.oColour), 0);
        chk({tag, "_clear"},    int'(oPipeClear), 0);
        chk({tag, "_busy"},     int'(oBusy), 0);
        chk({tag, "_done"},     int'(oFrameDone), 0);
        chk({tag, "_timeout"},  int'(oTimeout), 0);
    endtask

    task automatic start_frame();
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        chk("start_busy",    int'(oBusy), 1);
        chk("start_ready",   int'(bus.oSrcReady), 1);
        chk("start_valid",   int'(bus.oValid), 0);
        chk("start_timeout", int'(oTimeout), 0);
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.iSrcValid = vecs[i].sv;
            bus.iSrcData  = vecs[i].d;
            step();
            chk($sformatf("vec%0d_valid", i), int'(bus.oValid), int'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_data", i),   int'(bus.oData), int'(vecs[i].ed));
                chk($sformatf("vec%0d_col", i),    int'(bus.oCol), vecs[i].ec);
                chk($sformatf("vec%0d_row", i),    int'(bus.oRow), vecs[i].er);
                chk($sformatf("vec%0d_colour", i), int'(bus.oColour), vecs[i].eclr);
            end
        end
        bus.iSrcValid = 1'b0;
    endtask

    // Called while the last pixel is on the output. pd_at = flush cycle index
    // on which iPipeDone is raised (0 = never).
    task automatic run_drain(input int pd_at, input int exp_n, input bit exp_to,
                             input bit start_in_clear);
        int n = 0;
        for (int k = 1; k <= MD + 2; k++) begin
            step();
            if (oPipeClear) break;
            n++;
            chk("drain_valid", int'(bus.oValid), 1);
            chk("drain_data",  int'(bus.oData), 0);
            chk("drain_tags",  int'({bus.oCol, bus.oRow, bus.oColour}), 0);
            chk("drain_busy",  int'(oBusy), 1);
            iPipeDone = (k == pd_at);
        end
        iPipeDone = 1'b0;
        chk("drain_len",     n, exp_n);
        chk("clear_pulse",   int'(oPipeClear), 1);
        chk("clear_done",    int'(oFrameDone), 1);
        chk("clear_valid",   int'(bus.oValid), 0);
        chk("clear_timeout", int'(oTimeout), int'(exp_to));
        iStart = start_in_clear;
        step();
        iStart = 1'b0;
        chk("idle_busy",    int'(oBusy), 0);
        chk("idle_done",    int'(oFrameDone), 0);
        chk("idle_clear",   int'(oPipeClear), 0);
        chk("idle_ready",   int'(bus.oSrcReady), 0);
        chk("idle_timeout", int'(oTimeout), int'(exp_to));
    endtask

    task automatic rand_frame(input int pd_at);
        int         n = 0;
        int         cyc = 0;
        bit         xf;
        logic [7:0] d;
        bit         in_win;
        start_frame();
        while (n < W * H && cyc < 200) begin
            xf = ($urandom_range(0, 9) < 6);
            d  = 8'($urandom);
            bus.iSrcValid = xf;
            bus.iSrcData  = d;
            step();
            cyc++;
            chk("rnd_valid", int'(bus.oValid), int'(xf));
            if (xf) begin
                chk("rnd_data",   int'(bus.oData), int'(d));
                chk("rnd_col",    int'(bus.oCol), n % W);
                chk("rnd_row",    int'(bus.oRow), n / W);
                chk("rnd_colour", int'(bus.oColour), bayer(n / W, n % W));
                n++;
            end
            chk("rnd_ready", int'(bus.oSrcReady), int'(n < W * H));
        end
        bus.iSrcValid = 1'b0;
        chk("rnd_count", n, W * H);
        in_win = (pd_at >= 1 && pd_at <= MD);
        run_drain(pd_at, in_win ? pd_at : MD, !in_win, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // back-to-back: data 1..8
        vecs[0]  = '{1, 8'd1,  1, 8'd1,  0, 0, 0};
        vecs[1]  = '{1, 8'd2,  1, 8'd2,  1, 0, 1};
        vecs[2]  = '{1, 8'd3,  1, 8'd3,  2, 0, 0};
        vecs[3]  = '{1, 8'd4,  1, 8'd4,  3, 0, 1};
        vecs[4]  = '{1, 8'd5,  1, 8'd5,  0, 1, 2};
        vecs[5]  = '{1, 8'd6,  1, 8'd6,  1, 1, 0};
        vecs[6]  = '{1, 8'd7,  1, 8'd7,  2, 1, 2};
        vecs[7]  = '{1, 8'd8,  1, 8'd8,  3, 1, 0};
        // stall: 3 idle cycles after pixel 2
        vecs[8]  = '{1, 8'd11, 1, 8'd11, 0, 0, 0};
        vecs[9]  = '{1, 8'd12, 1, 8'd12, 1, 0, 1};
        vecs[10] = '{0, 8'hAA, 0, 8'd0,  0, 0, 0};
        vecs[11] = '{0, 8'hBB, 0, 8'd0,  0, 0, 0};
        vecs[12] = '{0, 8'hCC, 0, 8'd0,  0, 0, 0};
        vecs[13] = '{1, 8'd13, 1, 8'd13, 2, 0, 0};
        vecs[14] = '{1, 8'd14, 1, 8'd14, 3, 0, 1};
        vecs[15] = '{1, 8'd15, 1, 8'd15, 0, 1, 2};
        vecs[16] = '{1, 8'd16, 1, 8'd16, 1, 1, 0};
        vecs[17] = '{1, 8'd17, 1, 8'd17, 2, 1, 2};
        vecs[18] = '{1, 8'd18, 1, 8'd18, 3, 1, 0};

        bus.iSrcValid = 1'b0;
        bus.iSrcData  = 8'd0;
        step();
        step();
        chk_all_zero("reset");
        reset = 1'b1;
        step();
        step();
        chk("wait_start_busy", int'(oBusy), 0);

        // iteration + drain/done, with an iStart dropped during CLEAR
        start_frame();
        apply(0, 7);
        chk("last_ready", int'(bus.oSrcReady), 0);
        run_drain(5, 5, 1'b0, 1'b1);

        // stall + timeout, timeout sticky until next iStart
        start_frame();
        apply(8, 18);
        run_drain(0, MD, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sticky_timeout", int'(oTimeout), 1);
        end

        // iPipeDone coinciding with the final drain count wins
        start_frame();
        apply(0, 7);
        run_drain(MD, MD, 1'b0, 1'b0);

        for (int f = 0; f < 6; f++) rand_frame(int'($urandom_range(1, MD + 2)));

        // reset mid-FEED after pixel 5
        start_frame();
        apply(0, 4);
        #2 reset = 1'b0;
        #1 chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_done", int'(oFrameDone), 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_idle_busy", int'(oBusy), 0);
        end
        start_frame();
        apply(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/isp_frame_ctrl.md
ISP_FRAME_CTRL -- requirements
Module: isp_frame_ctrl

Interface
REQ-001 The block SHALL have parameter width, default 320, meaning active pixels per row.
REQ-002 The block SHALL have parameter height, default 240, meaning active rows per frame.
REQ-003 The block SHALL have parameter maxDrain, default 4096, meaning the drain-cycle limit before a forced timeout.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-006 The block SHALL have port iStart, input, 1 bit, meaning a frame-start request.
REQ-007 The block SHALL have ports iSrcValid (input, 1), iSrcData (input, 8), and oSrcReady (output, 1), meaning the RAW Bayer source handshake.
REQ-008 The block SHALL have ports oValid (output, 1) and oData (output, 8), meaning the drive to the pipeline iValid/iData.
REQ-009 The block SHALL have ports oCol (output, clog2(width)), oRow (output, clog2(height)), and oColour (output, 2; 0=G, 1=B, 2=R), meaning sideband tags for oData.
REQ-010 The block SHALL have port iPipeDone, input, 1 bit, meaning the pipeline last-pixel-out flag (oDoneDemosaic).
REQ-011 The block SHALL have port oPipeClear, output, 1 bit, meaning a synchronous clear to the pipeline.
REQ-012 The block SHALL have ports oBusy (output, 1), oFrameDone (output, 1, pulse), and oTimeout (output, 1, sticky), meaning frame status.

Function
REQ-013 The FSM SHALL have states IDLE, FEED, DRAIN and CLEAR; oBusy SHALL be 1 in every state except IDLE.
REQ-014 IDLE SHALL go to FEED on iStart=1, zeroing the column/row counters and the drain counter; iStart SHALL be ignored in every other state.
REQ-015 In FEED, oSrcReady SHALL be 1; a transfer occurs on a cycle with iSrcValid=1 and oSrcReady=1.
REQ-016 A transfer SHALL produce oValid=1 with oData=iSrcData on the next cycle (latency 1), with oCol/oRow/oColour registered alongside it.
REQ-017 A FEED cycle without a transfer SHALL produce oValid=0 on the next cycle, so the pipeline stalls.
REQ-018 oColour SHALL follow the Bayer phase: even row, even col → G; even row, odd col → B; odd row, even col → R; odd row, odd col → G.
REQ-019 The column SHALL increment per transfer and wrap from width-1 to 0, and the row SHALL increment on that wrap.
REQ-020 The transfer at (height-1, width-1) SHALL move the FSM to DRAIN, and oSrcReady SHALL be 0 from the next cycle.
REQ-021 iPipeDone SHALL be ignored in FEED.
REQ-022 In DRAIN, oValid SHALL be 1, oData 0, oCol/oRow/oColour 0, and the drain counter SHALL increment every cycle.
REQ-023 DRAIN SHALL go to CLEAR on iPipeDone=1.
REQ-024 DRAIN SHALL otherwise go to CLEAR when the drain counter reaches maxDrain-1, setting oTimeout=1.
REQ-025 If iPipeDone=1 coincides with the maxDrain-1 count, iPipeDone SHALL win and oTimeout SHALL stay unchanged.
REQ-026 CLEAR SHALL last exactly one cycle with oPipeClear=1, oFrameDone=1 and oValid=0, then return to IDLE.
REQ-027 iStart asserted during CLEAR SHALL be dropped; a new frame SHALL require iStart in IDLE.
REQ-028 oTimeout SHALL clear only on reset or on the next IDLE→FEED transition.
REQ-029 Counter widths SHALL be clog2 of their limit, and no counter SHALL exceed its limit.

Reset
REQ-030 reset=0 SHALL immediately force IDLE and set every output and counter to 0 (oSrcReady=0, oValid=0, oData=0, oPipeClear=0, oBusy=0, oFrameDone=0, oTimeout=0).
REQ-031 Reset asserted mid-FEED or mid-DRAIN SHALL abandon the frame and emit no oFrameDone.
REQ-032 After reset deassertion the block SHALL wait for iStart.

Verification (width=4, height=2, maxDrain=8)
REQ-033 Iteration SHALL be verified: iStart then 8 back-to-back transfers of data 1..8 → oValid high for 8 cycles starting 1 cycle after the first transfer, oColour sequence G,B,G,B,R,G,R,G, oRow 0,0,0,0,1,1,1,1.
REQ-034 Stall SHALL be verified: iSrcValid low for 3 cycles after pixel 2 → exactly 3 oValid=0 cycles, no pixel lost or duplicated, oCol resumes at 2.
REQ-035 Drain/done SHALL be verified: iPipeDone asserted on the 5th DRAIN cycle → 5 cycles of oValid=1 with oData=0, then a single cycle of oPipeClear=oFrameDone=1, then oBusy=0.
REQ-036 Timeout SHALL be verified: iPipeDone held 0 → CLEAR after 8 DRAIN cycles, oTimeout=1 held until the next iStart.
REQ-037 Priority SHALL be verified: iPipeDone=1 on DRAIN cycle 8 → CLEAR with oTimeout=0.
REQ-038 Reset SHALL be verified: reset=0 after pixel 5 → all outputs 0 asynchronously, no oFrameDone; a subsequent iStart restarts at oCol=0, oRow=0.
